// File: rtl/bfly_out_merge.sv
// bfly_out_merge
//   Output reorder stage after a radix-2 DIF butterfly. It takes DEPTH pairs of
//   sum/difference lane vectors, with NUM lanes per cycle. The sum vectors go
//   straight out with one cycle of latency. The difference vectors are stored
//   in a buffer and then sent as one contiguous burst, so the next stage sees
//   all sums first and then all differences.
//
// Ports
//   clk, rstn            clock; asynchronous active-low reset
//   valid_in             sum_* / dif_* carry a valid pair this cycle
//   sum_re, sum_im       butterfly plus outputs   (NUM lanes, signed WIDTH)
//   dif_re, dif_im       butterfly minus outputs  (NUM lanes, signed WIDTH)
//   dout_re, dout_im     merged output stream     (NUM lanes, signed WIDTH)
//   valid_out            dout_* valid
//   sop                  pulse with the first sum vector of a block
//   eop                  pulse with the last difference vector of a block
//   err_ovf              sticky: valid_in arrived while draining (input dropped)
//
// Build option
//   BFLY_MERGE_SCALE_EN  when defined, each output component is (x + 1) >>> 1.
//                        This is round-half-up scaling by 1/2.
module bfly_out_merge #(
    parameter int WIDTH = 10,
    parameter int NUM   = 16,
    parameter int DEPTH = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] sum_re  [0:NUM-1],
    input  logic signed [WIDTH-1:0] sum_im  [0:NUM-1],
    input  logic signed [WIDTH-1:0] dif_re  [0:NUM-1],
    input  logic signed [WIDTH-1:0] dif_im  [0:NUM-1],
    output logic signed [WIDTH-1:0] dout_re [0:NUM-1],
    output logic signed [WIDTH-1:0] dout_im [0:NUM-1],
    output logic                    valid_out,
    output logic                    sop,
    output logic                    eop,
    output logic                    err_ovf
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, PASS, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, wr_ptr_nxt;
    logic [PW-1:0]   rd_ptr, rd_ptr_nxt;
    logic            accept;
    logic            rd_en;
    logic            last_rd;
    logic            ovf_hit;

    logic signed [WIDTH-1:0] mem_re [0:DEPTH-1][0:NUM-1];
    logic signed [WIDTH-1:0] mem_im [0:DEPTH-1][0:NUM-1];

    function automatic logic signed [WIDTH-1:0] scale(input logic signed [WIDTH-1:0] x);
`ifdef BFLY_MERGE_SCALE_EN
        logic signed [WIDTH:0] t;
        // The sum is formed in WIDTH+1 bits, so x = max cannot wrap.
        // t[WIDTH:1] is t >>> 1 truncated to WIDTH bits.
        t = {x[WIDTH-1], x} + (WIDTH+1)'(1);
        return t[WIDTH:1];
`else
        return x;
`endif
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nxt;
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // IDLE and PASS share the accept path. In IDLE, wr_ptr is always 0,
    // so the first pair lands in slot 0. When DEPTH=1 that first pair is
    // also the last one, and the FSM moves straight to DRAIN.
    always_comb begin
        state_nxt  = state;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        accept     = 1'b0;
        rd_en      = 1'b0;
        last_rd    = 1'b0;
        ovf_hit    = 1'b0;
        case (state)
            IDLE, PASS: begin
                if (valid_in) begin
                    accept = 1'b1;
                    if (wr_ptr == PW'(DEPTH-1)) begin
                        wr_ptr_nxt = '0;
                        state_nxt  = DRAIN;
                    end else begin
                        wr_ptr_nxt = wr_ptr + PW'(1);
                        state_nxt  = PASS;
                    end
                end
            end
            DRAIN: begin
                rd_en   = 1'b1;
                ovf_hit = valid_in;
                if (rd_ptr == PW'(DEPTH-1)) begin
                    last_rd    = 1'b1;
                    rd_ptr_nxt = '0;
                    state_nxt  = IDLE;
                end else begin
                    rd_ptr_nxt = rd_ptr + PW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Difference buffer: contents need no reset
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                mem_re[wr_ptr][i] <= dif_re[i];
                mem_im[wr_ptr][i] <= dif_im[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                dout_re[i] <= '0;
                dout_im[i] <= '0;
            end
            valid_out <= 1'b0;
            sop       <= 1'b0;
            eop       <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            sop       <= 1'b0;
            eop       <= 1'b0;
            valid_out <= accept | rd_en;
            if (ovf_hit) begin
                err_ovf <= 1'b1;
            end
            if (accept) begin
                for (int unsigned i = 0; i < NUM; i++) begin
                    dout_re[i] <= scale(sum_re[i]);
                    dout_im[i] <= scale(sum_im[i]);
                end
                sop <= (state == IDLE);
            end else if (rd_en) begin
                for (int unsigned i = 0; i < NUM; i++) begin
                    dout_re[i] <= scale(mem_re[rd_ptr][i]);
                    dout_im[i] <= scale(mem_im[rd_ptr][i]);
                end
                eop <= last_rd;
            end
        end
    end

endmodule

// File: tb/tb_bfly_out_merge.sv
// Testbench for bfly_out_merge.
// The reference model is a queue of pending difference vectors plus a count of
// accepted pairs. Every output cycle is compared against that model.
module tb_bfly_out_merge;

    localparam int WIDTH = 10;
    localparam int NUM   = 16;
    localparam int DEPTH = 16;
    localparam int VW    = 2*NUM*WIDTH;

    typedef logic [VW-1:0] vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid_in = 1'b0;
    logic signed [WIDTH-1:0] sum_re  [0:NUM-1];
    logic signed [WIDTH-1:0] sum_im  [0:NUM-1];
    logic signed [WIDTH-1:0] dif_re  [0:NUM-1];
    logic signed [WIDTH-1:0] dif_im  [0:NUM-1];
    logic signed [WIDTH-1:0] dout_re [0:NUM-1];
    logic signed [WIDTH-1:0] dout_im [0:NUM-1];
    logic valid_out, sop, eop, err_ovf;
    vec_t dout_pk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    vec_t m_difq[$];
    int   m_acc;
    bit   m_drain;
    vec_t m_dout;
    bit   m_valid, m_sop, m_eop, m_ovf;

    always #5 clk = ~clk;

    bfly_out_merge #(.WIDTH(WIDTH), .NUM(NUM), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .valid_in(valid_in),
        .sum_re(sum_re), .sum_im(sum_im), .dif_re(dif_re), .dif_im(dif_im),
        .dout_re(dout_re), .dout_im(dout_im),
        .valid_out(valid_out), .sop(sop), .eop(eop), .err_ovf(err_ovf)
    );

    // Lane n real part is at field n, imaginary part at field NUM+n
    always_comb begin
        dout_pk = '0;
        for (int n = 0; n < NUM; n++) begin
            dout_pk[n*WIDTH +: WIDTH]       = dout_re[n];
            dout_pk[(NUM+n)*WIDTH +: WIDTH] = dout_im[n];
        end
    end

    function automatic int half_up(input int x);
`ifdef BFLY_MERGE_SCALE_EN
        int v;
        v = x + 1;
        return (v >= 0) ? v / 2 : -((1 - v) / 2);   // floor(v/2)
`else
        return x;
`endif
    endfunction

    function automatic vec_t scale_vec(input vec_t v);
        vec_t r;
        logic signed [WIDTH-1:0] f;
        int x;
        for (int i = 0; i < 2*NUM; i++) begin
            f = v[i*WIDTH +: WIDTH];
            x = f;
            r[i*WIDTH +: WIDTH] = WIDTH'(half_up(x));
        end
        return r;
    endfunction

    function automatic vec_t rvec();
        vec_t r;
        for (int i = 0; i < 2*NUM; i++) r[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        return r;
    endfunction

    task automatic model_reset();
        m_difq.delete();
        m_acc = 0; m_drain = 0; m_dout = '0;
        m_valid = 0; m_sop = 0; m_eop = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit v, input vec_t s, input vec_t d);
        m_sop = 0;
        m_eop = 0;
        if (m_drain) begin
            m_dout  = scale_vec(m_difq.pop_front());
            m_valid = 1;
            if (v) m_ovf = 1;
            if (m_difq.size() == 0) begin
                m_eop = 1;
                m_drain = 0;
            end
        end else if (v) begin
            m_dout  = scale_vec(s);
            m_valid = 1;
            m_sop   = (m_acc == 0);
            m_difq.push_back(d);
            m_acc++;
            if (m_acc == DEPTH) begin
                m_drain = 1;
                m_acc = 0;
            end
        end else begin
            m_valid = 0;
        end
    endtask

    task automatic chk(input string tag, input vec_t obs, input vec_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid_out", vec_t'(valid_out), vec_t'(m_valid));
        chk("sop",       vec_t'(sop),       vec_t'(m_sop));
        chk("eop",       vec_t'(eop),       vec_t'(m_eop));
        chk("err_ovf",   vec_t'(err_ovf),   vec_t'(m_ovf));
        chk("dout",      dout_pk,           m_dout);
    endtask

    task automatic drive(input bit v, input vec_t s, input vec_t d);
        valid_in = v;
        for (int n = 0; n < NUM; n++) begin
            sum_re[n] = s[n*WIDTH +: WIDTH];
            sum_im[n] = s[(NUM+n)*WIDTH +: WIDTH];
            dif_re[n] = d[n*WIDTH +: WIDTH];
            dif_im[n] = d[(NUM+n)*WIDTH +: WIDTH];
        end
    endtask

    // Drive inputs, let one edge capture them, then check just after the edge
    task automatic cyc(input bit v, input vec_t s, input vec_t d);
        drive(v, s, d);
        @(posedge clk);
        model_step(v, s, d);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, rvec(), rvec());
    endtask

    initial begin
        vec_t s, d;
        logic signed [WIDTH-1:0] lane0;
        model_reset();

        // Reset held with valid_in high: every output stays zero
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, rvec(), rvec());
            @(posedge clk);
            #1;
            check_all();
        end
        rstn = 1'b1;
        idle(2);

        // Gap-free block: pair k, lane n has sum=k*16+n and dif=-(k*16+n)
        for (int k = 0; k < DEPTH; k++) begin
            s = rvec();
            d = rvec();
            for (int n = 0; n < NUM; n++) begin
                s[n*WIDTH +: WIDTH] = WIDTH'(k*16 + n);
                d[n*WIDTH +: WIDTH] = WIDTH'(-(k*16 + n));
            end
            cyc(1'b1, s, d);
        end
        idle(DEPTH + 2);

        // Gappy PASS: valid_in toggles 1/0
        for (int i = 0; i < 2*DEPTH; i++) cyc((i % 2) == 0, rvec(), rvec());
        idle(DEPTH + 2);

        // Overflow: valid_in on the 3rd drain cycle
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, rvec(), rvec());
        for (int j = 0; j < DEPTH; j++) cyc(j == 2, rvec(), rvec());
        idle(3);

        // Reset asserted during the 8th drain cycle
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, rvec(), rvec());
        idle(7);
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rstn = 1'b1;
        idle(1);
        for (int k = 0; k < DEPTH; k++) cyc(1'b1, rvec(), rvec());
        idle(DEPTH + 2);

`ifdef BFLY_MERGE_SCALE_EN
        // Rounding corner values on lane 0 real
        for (int k = 0; k < DEPTH; k++) begin
            s = rvec();
            case (k)
                0: s[0 +: WIDTH] = 10'sd511;
                1: s[0 +: WIDTH] = -10'sd512;
                2: s[0 +: WIDTH] = 10'sd3;
                3: s[0 +: WIDTH] = -10'sd3;
                default: ;
            endcase
            cyc(1'b1, s, rvec());
            lane0 = dout_re[0];
            case (k)
                0: chk("scale_511", vec_t'(lane0), vec_t'(10'sd256));
                1: chk("scale_m512", vec_t'(lane0), vec_t'(-10'sd256));
                2: chk("scale_3", vec_t'(lane0), vec_t'(10'sd2));
                3: chk("scale_m3", vec_t'(lane0), vec_t'(-10'sd1));
                default: ;
            endcase
        end
        idle(DEPTH + 2);
`endif

        // Random traffic, including overflow attempts
        for (int i = 0; i < 400; i++) cyc(($urandom % 3) != 0, rvec(), rvec());
        idle(DEPTH + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
